fsm_watchdog_monitor: RTL and testbench

Synthesizable multi-channel watchdog for control-path state machines such as the UART frame parser and its TX/RX siblings. It replaces simulation-only lock-up checks with logic that can also be built into hardware. Each channel watches one FSM state vector and one "valid hold" strobe, and flags two conditions: a non-idle state held too long, or a hold strobe that never releases. It latches a first-error snapshot, keeps a saturating error count and can optionally pulse a per-channel recovery request. It sits beside the protocol FSMs, and its status feeds the register block and the interrupt line.

---
 rtl/fsm_watchdog_monitor_pkg.sv | 22 ++
 rtl/fsm_watchdog_monitor_if.sv | 44 ++++
 rtl/fsm_watchdog_monitor_channel.sv | 83 ++++++++
 rtl/fsm_watchdog_monitor.sv | 114 +++++++++++
 tb/tb_fsm_watchdog_monitor.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/fsm_watchdog_monitor_pkg.sv
// Shared types for the FSM watchdog monitor: event kind, capture record and sizing helper.
package fsm_wdog_pkg;

    localparam int unsigned MAX_CH_W    = 4;
    localparam int unsigned MAX_STATE_W = 16;

    typedef enum logic {
        EV_STUCK = 1'b0,
        EV_HOLD  = 1'b1
    } ev_kind_e;

    typedef struct packed {
        logic [MAX_CH_W-1:0]    ch;
        ev_kind_e               kind;
        logic [MAX_STATE_W-1:0] state;
    } cap_t;

    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fsm_watchdog_monitor_if.sv
// Monitor-side bundle: configuration, watched FSM signals and watchdog status.
interface fsm_watchdog_monitor_if #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned STATE_W   = 4,
    parameter int unsigned TIMEOUT_W = 16,
    parameter int unsigned ERRCNT_W  = 16
);
    import fsm_wdog_pkg::*;

    localparam int unsigned CH_W = ch_width(NUM_CH);

    logic                       enable;
    logic [TIMEOUT_W-1:0]       cfg_state_timeout;
    logic [TIMEOUT_W-1:0]       cfg_hold_timeout;
    logic [NUM_CH*STATE_W-1:0]  state_i;
    logic [NUM_CH-1:0]          hold_i;
    logic [NUM_CH-1:0]          flag_clr_i;
    logic                       cap_clr_i;

    logic [NUM_CH-1:0]          stuck_flag_o;
    logic [NUM_CH-1:0]          hold_flag_o;
    logic                       irq_o;
    logic [NUM_CH-1:0]          recover_o;
    logic                       cap_valid_o;
    logic [CH_W-1:0]            cap_ch_o;
    logic                       cap_kind_o;
    logic [STATE_W-1:0]         cap_state_o;
    logic [ERRCNT_W-1:0]        err_count_o;

    modport master (
        output enable, cfg_state_timeout, cfg_hold_timeout, state_i, hold_i,
               flag_clr_i, cap_clr_i,
        input  stuck_flag_o, hold_flag_o, irq_o, recover_o, cap_valid_o,
               cap_ch_o, cap_kind_o, cap_state_o, err_count_o
    );

    modport slave (
        input  enable, cfg_state_timeout, cfg_hold_timeout, state_i, hold_i,
               flag_clr_i, cap_clr_i,
        output stuck_flag_o, hold_flag_o, irq_o, recover_o, cap_valid_o,
               cap_ch_o, cap_kind_o, cap_state_o, err_count_o
    );

endinterface

// File: rtl/fsm_watchdog_monitor_channel.sv
// One watchdog channel: stuck-state and hold-overrun counters with sticky flags.
module fsm_wdog_channel #(
    parameter int unsigned        STATE_W      = 4,
    parameter int unsigned        TIMEOUT_W    = 16,
    parameter logic [STATE_W-1:0] IDLE_CODE    = '0,
    parameter int unsigned        AUTO_RECOVER = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_enable,
    input  logic [TIMEOUT_W-1:0] i_cfg_state_timeout,
    input  logic [TIMEOUT_W-1:0] i_cfg_hold_timeout,
    input  logic [STATE_W-1:0]   i_state,
    input  logic                 i_hold,
    input  logic                 i_flag_clr,
    output logic                 o_stuck_ev_c,
    output logic                 o_hold_ev_c,
    output logic                 o_stuck_flag,
    output logic                 o_hold_flag,
    output logic                 o_recover
);

    logic [STATE_W-1:0]   r_prev_state;
    logic [TIMEOUT_W-1:0] r_scnt;
    logic [TIMEOUT_W-1:0] r_hcnt;
    logic                 r_stuck_flag;
    logic                 r_hold_flag;
    logic                 r_recover;

    logic [TIMEOUT_W-1:0] w_scnt_nxt;
    logic [TIMEOUT_W-1:0] w_hcnt_nxt;
    logic                 w_stuck_arm;
    logic                 w_hold_arm;

    // Counters saturate at their threshold, so a lowered threshold leaves them parked until re-armed.
    always_comb begin
        w_scnt_nxt  = '0;
        w_hcnt_nxt  = '0;
        w_stuck_arm = 1'b0;
        w_hold_arm  = 1'b0;
        if (i_enable && (i_state != IDLE_CODE) && (i_state == r_prev_state)) begin
            w_stuck_arm = 1'b1;
            w_scnt_nxt  = (r_scnt >= i_cfg_state_timeout) ? r_scnt : r_scnt + TIMEOUT_W'(1);
        end
        if (i_enable && i_hold) begin
            w_hold_arm = 1'b1;
            w_hcnt_nxt = (r_hcnt >= i_cfg_hold_timeout) ? r_hcnt : r_hcnt + TIMEOUT_W'(1);
        end
    end

    assign o_stuck_ev_c = w_stuck_arm && (i_cfg_state_timeout != '0) &&
                          (r_scnt == i_cfg_state_timeout - TIMEOUT_W'(1));
    assign o_hold_ev_c  = w_hold_arm && (i_cfg_hold_timeout != '0) &&
                          (r_hcnt == i_cfg_hold_timeout - TIMEOUT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_state <= IDLE_CODE;
            r_scnt       <= '0;
            r_hcnt       <= '0;
            r_stuck_flag <= 1'b0;
            r_hold_flag  <= 1'b0;
            r_recover    <= 1'b0;
        end else begin
            r_prev_state <= i_state;
            r_scnt       <= w_scnt_nxt;
            r_hcnt       <= w_hcnt_nxt;
            r_recover    <= (AUTO_RECOVER != 0) && o_stuck_ev_c;
            // Flags are frozen while disabled; a new event beats a same-edge clear.
            if (i_enable) begin
                if (o_stuck_ev_c)    r_stuck_flag <= 1'b1;
                else if (i_flag_clr) r_stuck_flag <= 1'b0;
                if (o_hold_ev_c)     r_hold_flag  <= 1'b1;
                else if (i_flag_clr) r_hold_flag  <= 1'b0;
            end
        end
    end

    assign o_stuck_flag = r_stuck_flag;
    assign o_hold_flag  = r_hold_flag;
    assign o_recover    = r_recover;

endmodule

// File: rtl/fsm_watchdog_monitor.sv
// Multi-channel FSM watchdog: per-channel detectors plus first-event capture, error count and irq.
module fsm_watchdog_monitor
    import fsm_wdog_pkg::*;
#(
    parameter int unsigned        NUM_CH       = 2,
    parameter int unsigned        STATE_W      = 4,
    parameter logic [STATE_W-1:0] IDLE_CODE    = '0,
    parameter int unsigned        TIMEOUT_W    = 16,
    parameter int unsigned        ERRCNT_W     = 16,
    parameter int unsigned        AUTO_RECOVER = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    fsm_watchdog_monitor_if.slave  mon
);

    localparam int unsigned CH_W  = ch_width(NUM_CH);
    localparam int unsigned POP_W = $clog2(2*NUM_CH + 1);
    localparam int unsigned SUM_W = ERRCNT_W + 1;

    logic [NUM_CH-1:0]   w_stuck_ev;
    logic [NUM_CH-1:0]   w_hold_ev;
    logic [NUM_CH-1:0]   w_stuck_flag;
    logic [NUM_CH-1:0]   w_hold_flag;
    logic [NUM_CH-1:0]   w_recover;

    cap_t                w_cap_nxt;
    logic                w_any_ev;
    logic [POP_W-1:0]    w_pop;
    logic [SUM_W-1:0]    w_sum;
    logic [ERRCNT_W-1:0] w_cnt_nxt;

    cap_t                r_cap;
    logic                r_cap_valid;
    logic [ERRCNT_W-1:0] r_err_count;
    logic                r_irq;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        fsm_wdog_channel #(
            .STATE_W      (STATE_W),
            .TIMEOUT_W    (TIMEOUT_W),
            .IDLE_CODE    (IDLE_CODE),
            .AUTO_RECOVER (AUTO_RECOVER)
        ) u_ch (
            .clk                 (clk),
            .rst                 (rst),
            .i_enable            (mon.enable),
            .i_cfg_state_timeout (mon.cfg_state_timeout),
            .i_cfg_hold_timeout  (mon.cfg_hold_timeout),
            .i_state             (mon.state_i[g*STATE_W +: STATE_W]),
            .i_hold              (mon.hold_i[g]),
            .i_flag_clr          (mon.flag_clr_i[g]),
            .o_stuck_ev_c        (w_stuck_ev[g]),
            .o_hold_ev_c         (w_hold_ev[g]),
            .o_stuck_flag        (w_stuck_flag[g]),
            .o_hold_flag         (w_hold_flag[g]),
            .o_recover           (w_recover[g])
        );
    end

    // Scan high-to-low so the lowest active channel is the one left standing; stuck beats hold.
    always_comb begin
        w_cap_nxt = '0;
        w_any_ev  = 1'b0;
        w_pop     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_stuck_ev[i] || w_hold_ev[i]) begin
                w_any_ev        = 1'b1;
                w_cap_nxt.ch    = MAX_CH_W'(i);
                w_cap_nxt.kind  = w_stuck_ev[i] ? EV_STUCK : EV_HOLD;
                w_cap_nxt.state = MAX_STATE_W'(mon.state_i[i*STATE_W +: STATE_W]);
            end
            w_pop = w_pop + POP_W'(w_stuck_ev[i]) + POP_W'(w_hold_ev[i]);
        end
    end

    // A same-edge clear restarts the count from this edge's events.
    always_comb begin
        w_sum     = (mon.cap_clr_i ? SUM_W'(0) : SUM_W'(r_err_count)) + SUM_W'(w_pop);
        w_cnt_nxt = w_sum[ERRCNT_W] ? '1 : w_sum[ERRCNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap       <= '0;
            r_cap_valid <= 1'b0;
            r_err_count <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_irq <= (|w_stuck_flag) || (|w_hold_flag);
            if (mon.enable) begin
                if (w_any_ev && (!r_cap_valid || mon.cap_clr_i)) begin
                    r_cap       <= w_cap_nxt;
                    r_cap_valid <= 1'b1;
                end else if (mon.cap_clr_i) begin
                    r_cap       <= '0;
                    r_cap_valid <= 1'b0;
                end
                r_err_count <= w_cnt_nxt;
            end
        end
    end

    assign mon.stuck_flag_o = w_stuck_flag;
    assign mon.hold_flag_o  = w_hold_flag;
    assign mon.recover_o    = w_recover;
    assign mon.irq_o        = r_irq;
    assign mon.cap_valid_o  = r_cap_valid;
    assign mon.cap_ch_o     = CH_W'(r_cap.ch);
    assign mon.cap_kind_o   = 1'(r_cap.kind);
    assign mon.cap_state_o  = STATE_W'(r_cap.state);
    assign mon.err_count_o  = r_err_count;

endmodule

// File: tb/tb_fsm_watchdog_monitor.sv
// Directed bench for fsm_watchdog_monitor: table of timed input steps plus reset/toggle/idle sequences.
module tb_fsm_watchdog_monitor;

    logic clk;
    logic rst;

    fsm_watchdog_monitor_if #(
        .NUM_CH(2), .STATE_W(4), .TIMEOUT_W(16), .ERRCNT_W(16)
    ) u_if ();

    fsm_watchdog_monitor #(
        .NUM_CH(2), .STATE_W(4), .IDLE_CODE(4'h0),
        .TIMEOUT_W(16), .ERRCNT_W(16), .AUTO_RECOVER(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mon (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [15:0] cs;
        logic [15:0] chd;
        logic [7:0]  st;
        logic [1:0]  hold;
        logic [1:0]  fclr;
        logic        cclr;
        int          n;
        logic [1:0]  e_stuck;
        logic [1:0]  e_hflag;
        logic        e_irq;
        logic        e_cv;
        logic        e_cch;
        logic        e_ckind;
        logic [3:0]  e_cst;
        logic [15:0] e_cnt;
        logic [1:0]  e_rec;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_err;

    function automatic vec_t mk(
        input logic en, input logic [15:0] cs, input logic [15:0] chd, input logic [7:0] st,
        input logic [1:0] hold, input logic [1:0] fclr, input logic cclr, input int n,
        input logic [1:0] e_stuck, input logic [1:0] e_hflag, input logic e_irq,
        input logic e_cv, input logic e_cch, input logic e_ckind, input logic [3:0] e_cst,
        input logic [15:0] e_cnt, input logic [1:0] e_rec);
        vec_t v;
        v.en = en; v.cs = cs; v.chd = chd; v.st = st; v.hold = hold; v.fclr = fclr;
        v.cclr = cclr; v.n = n; v.e_stuck = e_stuck; v.e_hflag = e_hflag; v.e_irq = e_irq;
        v.e_cv = e_cv; v.e_cch = e_cch; v.e_ckind = e_ckind; v.e_cst = e_cst;
        v.e_cnt = e_cnt; v.e_rec = e_rec;
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [15:0] cs, input logic [15:0] chd,
                         input logic [7:0] st, input logic [1:0] hold, input logic [1:0] fclr,
                         input logic cclr);
        u_if.enable            = en;
        u_if.cfg_state_timeout = cs;
        u_if.cfg_hold_timeout  = chd;
        u_if.state_i           = st;
        u_if.hold_i            = hold;
        u_if.flag_clr_i        = fclr;
        u_if.cap_clr_i         = cclr;
    endtask

    task automatic check(input string nm, input logic [1:0] e_stuck, input logic [1:0] e_hflag,
                         input logic e_irq, input logic e_cv, input logic e_cch, input logic e_ckind,
                         input logic [3:0] e_cst, input logic [15:0] e_cnt, input logic [1:0] e_rec);
        n_vec++;
        if (u_if.stuck_flag_o !== e_stuck) begin
            n_err++; $display("FAIL %s stuck_flag got %b want %b", nm, u_if.stuck_flag_o, e_stuck);
        end
        if (u_if.hold_flag_o !== e_hflag) begin
            n_err++; $display("FAIL %s hold_flag got %b want %b", nm, u_if.hold_flag_o, e_hflag);
        end
        if (u_if.irq_o !== e_irq) begin
            n_err++; $display("FAIL %s irq got %b want %b", nm, u_if.irq_o, e_irq);
        end
        if (u_if.cap_valid_o !== e_cv) begin
            n_err++; $display("FAIL %s cap_valid got %b want %b", nm, u_if.cap_valid_o, e_cv);
        end
        if (u_if.cap_ch_o !== e_cch) begin
            n_err++; $display("FAIL %s cap_ch got %0d want %0d", nm, u_if.cap_ch_o, e_cch);
        end
        if (u_if.cap_kind_o !== e_ckind) begin
            n_err++; $display("FAIL %s cap_kind got %b want %b", nm, u_if.cap_kind_o, e_ckind);
        end
        if (u_if.cap_state_o !== e_cst) begin
            n_err++; $display("FAIL %s cap_state got %h want %h", nm, u_if.cap_state_o, e_cst);
        end
        if (u_if.err_count_o !== e_cnt) begin
            n_err++; $display("FAIL %s err_count got %0d want %0d", nm, u_if.err_count_o, e_cnt);
        end
        if (u_if.recover_o !== e_rec) begin
            n_err++; $display("FAIL %s recover got %b want %b", nm, u_if.recover_o, e_rec);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        //        en cs  chd  st     hold   fclr   cc  n  | stuck hflag irq cv ch kd st cnt rec
        vecs.push_back(mk(1, 8, 10, 8'h03, 2'b00, 2'b00, 0, 8,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(1, 8, 10, 8'h03, 2'b00, 2'b00, 0, 1,  2'b01, 2'b00, 0, 1, 0, 0, 3, 1, 2'b01));
        vecs.push_back(mk(1, 8, 10, 8'h03, 2'b00, 2'b00, 0, 1,  2'b01, 2'b00, 1, 1, 0, 0, 3, 1, 2'b00));
        vecs.push_back(mk(1, 8, 10, 8'h03, 2'b00, 2'b00, 0, 20, 2'b01, 2'b00, 1, 1, 0, 0, 3, 1, 2'b00));
        vecs.push_back(mk(1, 8, 10, 8'h03, 2'b00, 2'b01, 0, 1,  2'b00, 2'b00, 1, 1, 0, 0, 3, 1, 2'b00));
        vecs.push_back(mk(1, 8, 10, 8'h03, 2'b00, 2'b00, 0, 1,  2'b00, 2'b00, 0, 1, 0, 0, 3, 1, 2'b00));
        vecs.push_back(mk(1, 8, 10, 8'h03, 2'b00, 2'b00, 1, 1,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        // hold overrun on channel 1
        vecs.push_back(mk(1, 8, 10, 8'h00, 2'b10, 2'b00, 0, 9,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(1, 8, 10, 8'h00, 2'b10, 2'b00, 0, 1,  2'b00, 2'b10, 0, 1, 1, 1, 0, 1, 2'b00));
        vecs.push_back(mk(1, 8, 10, 8'h00, 2'b10, 2'b00, 0, 10, 2'b00, 2'b10, 1, 1, 1, 1, 0, 1, 2'b00));
        vecs.push_back(mk(1, 8, 10, 8'h00, 2'b00, 2'b11, 1, 1,  2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(1, 8, 10, 8'h00, 2'b00, 2'b00, 0, 1,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        // both channels stuck on one edge, then clear racing a new ch0 event
        vecs.push_back(mk(1, 8, 10, 8'h73, 2'b00, 2'b00, 0, 8,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(1, 8, 10, 8'h73, 2'b00, 2'b00, 0, 1,  2'b11, 2'b00, 0, 1, 0, 0, 3, 2, 2'b11));
        vecs.push_back(mk(1, 8, 10, 8'h74, 2'b00, 2'b00, 0, 8,  2'b11, 2'b00, 1, 1, 0, 0, 3, 2, 2'b00));
        vecs.push_back(mk(1, 8, 10, 8'h74, 2'b00, 2'b01, 0, 1,  2'b11, 2'b00, 1, 1, 0, 0, 3, 3, 2'b01));
        vecs.push_back(mk(0, 8, 10, 8'h74, 2'b00, 2'b00, 0, 5,  2'b11, 2'b00, 1, 1, 0, 0, 3, 3, 2'b00));
        vecs.push_back(mk(1, 8, 10, 8'h00, 2'b00, 2'b11, 1, 1,  2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00));
        // enable dropped mid-episode zeroes the count
        vecs.push_back(mk(1, 8, 10, 8'h05, 2'b00, 2'b00, 0, 5,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(0, 8, 10, 8'h05, 2'b00, 2'b00, 0, 10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(1, 8, 10, 8'h05, 2'b00, 2'b00, 0, 7,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(1, 8, 10, 8'h05, 2'b00, 2'b00, 0, 1,  2'b01, 2'b00, 0, 1, 0, 0, 5, 1, 2'b01));
        // threshold lowered under the running count, then threshold zero
        vecs.push_back(mk(1, 8, 10, 8'h06, 2'b00, 2'b01, 1, 1,  2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(1, 8, 10, 8'h06, 2'b00, 2'b00, 0, 6,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(1, 4, 10, 8'h06, 2'b00, 2'b00, 0, 5,  2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));
        vecs.push_back(mk(1, 0, 10, 8'h08, 2'b00, 2'b00, 0, 12, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00));

        rst = 1'b1;
        drive(1, 8, 10, 8'h00, 2'b00, 2'b00, 0);
        step(3);
        check("reset", 2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 16'd0, 2'b00);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].cs, vecs[i].chd, vecs[i].st, vecs[i].hold,
                  vecs[i].fclr, vecs[i].cclr);
            step(vecs[i].n);
            check($sformatf("vec%0d", i), vecs[i].e_stuck, vecs[i].e_hflag, vecs[i].e_irq,
                  vecs[i].e_cv, vecs[i].e_cch, vecs[i].e_ckind, vecs[i].e_cst,
                  vecs[i].e_cnt, vecs[i].e_rec);
        end

        // Reset mid-episode: ch0 scnt at 5 with a hold flag already captured
        drive(1, 8, 2, 8'h03, 2'b01, 2'b00, 0);
        step(6);
        check("pre_rst", 2'b00, 2'b01, 1, 1, 0, 1, 4'h3, 16'd1, 2'b00);
        rst = 1'b1;
        #1;
        check("rst_async", 2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 16'd0, 2'b00);
        step(1);
        drive(1, 8, 10, 8'h03, 2'b00, 2'b00, 0);
        rst = 1'b0;
        step(8);
        check("post_rst_8", 2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 16'd0, 2'b00);
        step(1);
        check("post_rst_9", 2'b01, 2'b00, 0, 1, 0, 0, 4'h3, 16'd1, 2'b01);
        step(1);
        check("recover_pulse_end", 2'b01, 2'b00, 1, 1, 0, 0, 4'h3, 16'd1, 2'b00);

        // Channel 1 toggling every 4 cycles never trips
        drive(1, 8, 10, 8'h00, 2'b00, 2'b11, 1);
        step(1);
        u_if.flag_clr_i = 2'b00;
        u_if.cap_clr_i  = 1'b0;
        for (int k = 0; k < 50; k++) begin
            u_if.state_i = (k % 2 == 1) ? 8'h60 : 8'h50;
            step(4);
        end
        check("toggle", 2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 16'd0, 2'b00);

        // Long idle never trips
        u_if.state_i = 8'h00;
        step(1000);
        check("idle", 2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 16'd0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
